// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem req/ack, redirect input and decode handshake.
// master = fetch_unit side, slave = memory/next-PC/decode side.
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] nPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instValid;
  logic        instReady;
  logic [31:0] inst;
  logic [31:0] PC;

  modport master (
    input  redirect, nPC, imemAck, imemData, instReady,
    output imemReq, imemAddr, instValid, inst, PC
  );

  modport slave (
    output redirect, nPC, imemAck, imemData, instReady,
    input  imemReq, imemAddr, instValid, inst, PC
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS fetch stage: one outstanding imem request, {PC,word} FIFO to decode.
// Ports: clk, rst_n (sync, active-low), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_q, fetch_d;
  logic [31:0]   drain_q, drain_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic          req_q;
  logic [31:0]   addr_q;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];
  logic          push, pop;
  logic          unused_npc;

  assign unused_npc    = ^bus.nPC[1:0];

  assign bus.imemReq   = req_q;
  assign bus.imemAddr  = addr_q;
  assign bus.instValid = count_q != '0;
  assign bus.inst      = word_mem[rd_q];
  assign bus.PC        = pc_mem[rd_q];

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    drain_d = drain_q;
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (bus.redirect) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      fetch_d = {bus.nPC[31:2], 2'b00};
      // An unacked request must finish at its old address.
      if (req_q && !bus.imemAck) begin
        state_d = DRAIN;
        if (state_q == FETCH) drain_d = fetch_q;
      end else begin
        state_d = FETCH;
      end
    end else if (state_q == DRAIN) begin
      if (bus.imemAck) state_d = FETCH;
    end else begin
      push = req_q & bus.imemAck;
      pop  = (count_q != '0) & bus.instReady;
      if (push) begin
        wr_d    = wr_q + AW'(1);
        fetch_d = fetch_q + 32'd4;
      end
      if (pop) rd_d = rd_q + AW'(1);
      count_d = count_q + (AW+1)'(push)
                        - (AW+1)'(pop);
    end
  end

  // imemReq/imemAddr are registered from next state so
  // they never depend combinationally on ack/redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      fetch_q <= RESET_PC;
      drain_q <= RESET_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      drain_q <= drain_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push) begin
        pc_mem[wr_q]   <= fetch_q;
        word_mem[wr_q] <= bus.imemData;
      end
      req_q  <= (state_d == DRAIN) || (count_d < FULL);
      addr_q <= (state_d == DRAIN) ? drain_d : fetch_d;
    end
  end
endmodule
